// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_pkg
// Purpose  : Shared definitions for the ALU sequencer:
//            - user-visible 2-bit state codes (driven on the LEDs)
//            - internal FSM state enumeration
//            - opcode constants agreed with the ALU datapath
// Revision : 1.0 - initial release
// ============================================================================
package ula_pkg;

  // Visible state codes
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_A    = 2'b01;
  localparam logic [1:0] ST_B    = 2'b10;  // also shown while executing
  localparam logic [1:0] ST_RES  = 2'b11;

  // Internal FSM states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4
  } fsm_e;

  // Opcodes understood by the ALU
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

endpackage
`default_nettype wire

// File: rtl/detector_borda.sv
`default_nettype none
// ============================================================================
// Module   : detector_borda
// Purpose  : Conditions one raw active-low board key into a single-cycle,
//            active-high press pulse: 2-FF synchronizer, optional debounce,
//            registered rising-edge detector. Key edge to pulse: 3 cycles
//            (debounce disabled).
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset
//            key_n_i  - raw key, active-low, asynchronous to clk
//            press_o  - one-cycle press pulse (registered)
// Options  : SEQ_ULA_DEBOUNCE_EN - insert a stability counter of
//            DEBOUNCE_CYCLES cycles between synchronizer and edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module detector_borda #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_i,
  output logic press_o
);

  // Synchronizer resets to the released level (1) so that leaving reset
  // with the key up never looks like a press.
  logic sync1_q, sync2_q;
  logic level;        // conditioned key, active-high
  logic level_prev_q;
  logic press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef SEQ_ULA_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             stable_n_q;   // accepted key level, still active-low
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_n_d;

  // Count consecutive cycles where the synchronized input differs from the
  // accepted level; returning to the accepted level restarts the count.
  always_comb begin
    cnt_d      = '0;
    stable_n_d = stable_n_q;
    if (sync2_q != stable_n_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_n_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      stable_n_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      stable_n_q <= stable_n_d;
    end
  end

  assign level = ~stable_n_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^32'(DEBOUNCE_CYCLES);
  assign level = ~sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_prev_q <= level;
      press_q      <= level & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/sequenciador_ula.sv
`default_nettype none
// ============================================================================
// Module   : sequenciador_ula
// Purpose  : Control FSM sequencing one ALU operation from board inputs.
//            Confirm presses capture A, then B, then OP (which also fires a
//            one-cycle alu_start); the result is latched on alu_done and
//            held until the next confirm. Cancel returns to idle from any
//            state and wins over a simultaneous confirm.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            sw_data, sw_op           - switch values for A/B and OP
//            key_confirm_n/cancel_n   - raw active-low keys (asynchronous)
//            alu_start (o)            - one-cycle start pulse
//            alu_done, alu_result (i) - ALU handshake and data
//            state (o)                - 00 idle, 01 A, 10 B/exec, 11 result
//            A/B/OP_registered, result, busy (o) - registered values
// Options  : SEQ_ULA_DEBOUNCE_EN - enables key debounce (DEBOUNCE_CYCLES).
// Revision : 1.0 - initial release
// ============================================================================
module sequenciador_ula
  import ula_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int OP_W            = 3,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_data,
  input  logic [OP_W-1:0]   sw_op,
  input  logic              key_confirm_n,
  input  logic              key_cancel_n,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] A_registered,
  output logic [DATA_W-1:0] B_registered,
  output logic [OP_W-1:0]   OP_registered,
  output logic [DATA_W-1:0] result,
  output logic              busy
);

  logic confirm_p, cancel_p;

  detector_borda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_det_confirm (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_confirm_n),
    .press_o (confirm_p)
  );

  detector_borda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_det_cancel (
    .clk     (clk),
    .rst     (rst),
    .key_n_i (key_cancel_n),
    .press_o (cancel_p)
  );

  fsm_e              fsm_q;
  logic [1:0]        state_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0]   op_q;
  logic              start_q, busy_q;

  // Visible state and busy are updated together with the FSM transition so
  // every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (cancel_p) begin
        fsm_q   <= S_IDLE;
        state_q <= ST_IDLE;
        a_q     <= '0;
        b_q     <= '0;
        op_q    <= '0;
        res_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (fsm_q)
          S_IDLE: if (confirm_p) begin
            a_q     <= sw_data;
            fsm_q   <= S_A;
            state_q <= ST_A;
          end
          S_A: if (confirm_p) begin
            b_q     <= sw_data;
            fsm_q   <= S_B;
            state_q <= ST_B;
          end
          S_B: if (confirm_p) begin
            op_q    <= sw_op;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            fsm_q   <= S_EXEC;
          end
          // alu_done is ignored during the start cycle itself, so a
          // stale done from a previous operation cannot complete this one.
          S_EXEC: if (alu_done && !start_q) begin
            res_q   <= alu_result;
            busy_q  <= 1'b0;
            fsm_q   <= S_RES;
            state_q <= ST_RES;
          end
          S_RES: if (confirm_p) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            fsm_q   <= S_IDLE;
            state_q <= ST_IDLE;
          end
          default: begin
            fsm_q   <= S_IDLE;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alu_start     = start_q;
  assign state         = state_q;
  assign A_registered  = a_q;
  assign B_registered  = b_q;
  assign OP_registered = op_q;
  assign result        = res_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_ula.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequenciador_ula
// Purpose  : Self-checking bench for sequenciador_ula with a behavioural ALU
//            and expected values derived from the operation sequence.
// Options  : SEQ_ULA_DEBOUNCE_EN - adds the glitch/stable-key steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequenciador_ula;
  import ula_pkg::*;

  localparam int DW = 8;
`ifdef SEQ_ULA_DEBOUNCE_EN
  localparam int HOLD = 20;
`else
  localparam int HOLD = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sw_data = '0;
  logic [2:0]    sw_op = '0;
  logic          key_confirm_n = 1'b1;
  logic          key_cancel_n = 1'b1;
  logic          alu_start, alu_done, busy;
  logic [DW-1:0] alu_result, A_registered, B_registered, result;
  logic [1:0]    state;
  logic [2:0]    OP_registered;

  always #5 clk = ~clk;

  sequenciador_ula #(.DATA_W(DW), .OP_W(3), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op),
    .key_confirm_n(key_confirm_n), .key_cancel_n(key_cancel_n),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .state(state), .A_registered(A_registered), .B_registered(B_registered),
    .OP_registered(OP_registered), .result(result), .busy(busy)
  );

  // Reference ALU arithmetic
  function automatic logic [DW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b,
                                           logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return a << 1;
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU: mode 0 = single done pulse on the dly-th cycle counting
  // the start cycle as the first, mode 1 = done tied high, mode 2 = manual.
  int       alu_mode = 0;
  int       dly = 3;
  int       alu_cnt = 0;
  logic     man_done = 1'b0;
  logic     force_ff = 1'b0;

  always @(posedge clk) begin
    if (alu_start) alu_cnt <= 1;
    else if (alu_cnt != 0 && alu_cnt < 200) alu_cnt <= alu_cnt + 1;
  end

  assign alu_done   = (alu_mode == 1) || man_done ||
                      (alu_mode == 0 && alu_cnt != 0 && alu_cnt == dly - 1);
  assign alu_result = force_ff ? 8'hFF : alu_fn(A_registered, B_registered, OP_registered);

  // Pulse-width monitor
  logic mon_en = 1'b0;
  int   start_cnt = 0;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      start_cnt <= start_cnt + int'(alu_start);
      busy_cnt  <= busy_cnt + int'(busy);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit conf, input bit canc, input int hold);
    @(negedge clk);
    key_confirm_n = ~conf;
    key_cancel_n  = ~canc;
    tick(hold);
    key_confirm_n = 1'b1;
    key_cancel_n  = 1'b1;
    tick(HOLD);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int budget);
    int n = 0;
    while (state !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(exp));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_A"}, 32'(A_registered), 0);
    chk({tag, "_B"}, 32'(B_registered), 0);
    chk({tag, "_OP"}, 32'(OP_registered), 0);
    chk({tag, "_res"}, 32'(result), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One full operation; expected busy length is dly (pulse) or 2 (tied).
  task automatic run_txn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [2:0] op, input int d, input int mode);
    alu_mode = mode;
    dly = d;
    sw_data = a;
    press(1, 0, HOLD);
    wait_state("st_A", ST_A, 60);
    chk("A_cap", 32'(A_registered), 32'(a));
    sw_data = b;
    press(1, 0, HOLD);
    wait_state("st_B", ST_B, 60);
    chk("B_cap", 32'(B_registered), 32'(b));
    chk("A_keep", 32'(A_registered), 32'(a));
    sw_op = op;
    sw_data = ~b;
    start_cnt = 0;
    busy_cnt = 0;
    mon_en = 1'b1;
    press(1, 0, HOLD);
    wait_state("st_RES", ST_RES, 80);
    tick(2);
    mon_en = 1'b0;
    chk("start_len", 32'(start_cnt), 1);
    chk("busy_len", 32'(busy_cnt), (mode == 1) ? 2 : d);
    chk("OP_cap", 32'(OP_registered), 32'(op));
    chk("result", 32'(result), 32'(alu_fn(a, b, op)));
    chk("busy_end", 32'(busy), 0);
    press(1, 0, HOLD);
    wait_state("st_IDLE", ST_IDLE, 60);
    chk_cleared("clr");
  endtask

  initial begin
    tick(3);
    chk("rst_start", 32'(alu_start), 0);
    chk("rst_state", 32'(state), 0);
    chk_cleared("rst");
    rst = 1'b0;
    tick(3);

    // Directed: A=2A, B=15, ADD, done on the third cycle -> 3F
    run_txn(8'h2A, 8'h15, OP_ADD, 3, 0);
    // Combinational ALU
    run_txn(8'hC3, 8'h5A, OP_XOR, 0, 1);
    // Randomized operations
    for (int i = 0; i < 4; i++)
      run_txn(DW'($urandom), DW'($urandom), 3'($urandom), int'($urandom_range(2, 6)), 0);

    // Confirm ignored during execution; late manual done completes it
    alu_mode = 2;
    sw_data = 8'h11; press(1, 0, HOLD); wait_state("x_A", ST_A, 60);
    sw_data = 8'h22; press(1, 0, HOLD); wait_state("x_B", ST_B, 60);
    sw_op = OP_SUB; press(1, 0, HOLD);
    chk("x_busy", 32'(busy), 1);
    press(1, 0, HOLD);
    chk("x_ignore_st", 32'(state), 32'(ST_B));
    chk("x_ignore_busy", 32'(busy), 1);
    @(negedge clk); man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    tick(2);
    chk("x_done_st", 32'(state), 32'(ST_RES));
    chk("x_done_res", 32'(result), 32'h11 - 32'h22 & 32'hFF);
    tick(10);
    chk("x_not_queued", 32'(state), 32'(ST_RES));
    press(0, 1, HOLD);
    wait_state("x_cancel_res", ST_IDLE, 60);
    chk_cleared("x_clr");

    // Cancel in EXEC; late done carrying FF must be ignored
    sw_data = 8'h33; press(1, 0, HOLD); wait_state("c_A", ST_A, 60);
    sw_data = 8'h44; press(1, 0, HOLD); wait_state("c_B", ST_B, 60);
    press(1, 0, HOLD);
    chk("c_busy", 32'(busy), 1);
    press(0, 1, HOLD);
    wait_state("c_idle", ST_IDLE, 60);
    tick(2);
    force_ff = 1'b1; man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    tick(3); force_ff = 1'b0;
    chk("c_late_st", 32'(state), 32'(ST_IDLE));
    chk_cleared("c_clr");

    // Confirm held 100 cycles -> exactly one capture
    sw_data = 8'h5C;
    press(1, 0, 100);
    chk("h_state", 32'(state), 32'(ST_A));
    chk("h_A", 32'(A_registered), 32'h5C);
    chk("h_B", 32'(B_registered), 0);
    // Simultaneous confirm and cancel in S_A -> cancel wins
    press(1, 1, HOLD);
    chk("sim_state", 32'(state), 32'(ST_IDLE));
    chk_cleared("sim_clr");

    // Reset during execution
    alu_mode = 2;
    sw_data = 8'h01; press(1, 0, HOLD); wait_state("r_A", ST_A, 60);
    sw_data = 8'h02; press(1, 0, HOLD); wait_state("r_B", ST_B, 60);
    press(1, 0, HOLD);
    chk("r_busy", 32'(busy), 1);
    rst = 1'b1;
    tick(2);
    chk("r_start", 32'(alu_start), 0);
    chk("r_state", 32'(state), 0);
    chk_cleared("r_clr");
    rst = 1'b0;
    tick(3);

`ifdef SEQ_ULA_DEBOUNCE_EN
    // 5-cycle glitch rejected, 12-cycle press accepted
    sw_data = 8'h77;
    @(negedge clk); key_confirm_n = 1'b0;
    tick(5); key_confirm_n = 1'b1;
    tick(30);
    chk("db_glitch", 32'(state), 32'(ST_IDLE));
    @(negedge clk); key_confirm_n = 1'b0;
    tick(12); key_confirm_n = 1'b1;
    tick(30);
    chk("db_stable", 32'(state), 32'(ST_A));
    chk("db_A", 32'(A_registered), 32'h77);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sequenciador_ula.md
Name: sequenciador_ula

Overview:
- Control FSM that sequences one ALU operation from board inputs.
- Captures operand A, operand B and opcode OP from the switches on successive confirm presses, then issues a start to the ALU and waits for its done.
- Latches the ALU result and exposes the 2-bit user-visible state plus all registered values to the LED/display logic.
- Sits between the board I/O (switches, keys) and the ALU datapath.

Parameters:
- DATA_W, 8, operand and result width.
- OP_W, 3, opcode width.
- DEBOUNCE_CYCLES, 250000, number of stable cycles required to accept a key level (5 ms at 50 MHz); used only with the debounce feature.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- sw_data, input, DATA_W, switch value used for A or B.
- sw_op, input, OP_W, switch value used for OP.
- key_confirm_n, input, 1, raw confirm key, active-low, asynchronous to clk.
- key_cancel_n, input, 1, raw cancel key, active-low, asynchronous to clk.
- alu_start, output, 1, one-cycle start pulse to the ALU.
- alu_done, input, 1, ALU result valid; may be tied high for a combinational ALU.
- alu_result, input, DATA_W, ALU output.
- state, output, 2, visible state: 00 idle, 01 A held, 10 B held / executing, 11 result held.
- A_registered, output, DATA_W, captured A.
- B_registered, output, DATA_W, captured B.
- OP_registered, output, OP_W, captured OP.
- result, output, DATA_W, latched ALU result.
- busy, output, 1, high while waiting for alu_done.

Behaviour:
- Reset: rst is synchronous and active-high. On reset all outputs and registers are 0, state = 00, and the internal FSM is in S_IDLE.
- Key conditioning:
  - Each key passes through a 2-FF synchronizer and is then inverted to active-high.
  - The conditioned level feeds a rising-edge detector that produces a 1-cycle press pulse.
  - Latency from a key edge to the press pulse is 3 cycles, with debounce disabled.
- Internal FSM (visible state code in parentheses):
  - S_IDLE (00): on confirm, A_registered <= sw_data, go to S_A.
  - S_A (01): on confirm, B_registered <= sw_data, go to S_B.
  - S_B (10): on confirm, OP_registered <= sw_op, assert alu_start for exactly 1 cycle, go to S_EXEC.
  - S_EXEC (10): busy = 1.
    - On the cycle alu_done is 1: result <= alu_result, go to S_RES.
    - alu_done is sampled from the cycle after alu_start onward.
    - A combinational ALU (alu_done tied 1) therefore completes 1 cycle after the start pulse.
  - S_RES (11): on confirm, clear A, B, OP and result to 0, go to S_IDLE.
- Confirm presses in S_EXEC are ignored and are not queued.
- Cancel press:
  - From any state, cancel clears A, B, OP, result and busy and goes to S_IDLE on the next cycle.
  - In S_EXEC, a late alu_done is ignored once the block is back in S_IDLE.
- Simultaneous confirm and cancel pulses in the same cycle: cancel wins.
- A key held down produces only one press pulse; releasing and pressing again is required for the next step.
- Registered values change only on the clock edge of their capture. Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset asserted in any state, including S_EXEC, returns to the reset values on the next edge; alu_start is 0 during reset.

Optional Feature:
- Macro: SEQ_ULA_DEBOUNCE_EN.
- Defined:
  - A counter per key between the synchronizer and the edge detector.
  - The conditioned level updates only after the synchronized input has been stable for DEBOUNCE_CYCLES consecutive cycles.
  - Any change of the input restarts the count.
- Undefined:
  - The synchronizer output drives the edge detector directly.
  - No counter logic is generated and DEBOUNCE_CYCLES is unused.
  - Simulation benches use this configuration.

Decomposition:
- Package ula_pkg holds:
  - The visible state constants ST_IDLE = 2'b00, ST_A = 2'b01, ST_B = 2'b10, ST_RES = 2'b11.
  - The internal FSM enum (S_IDLE, S_A, S_B, S_EXEC, S_RES).
  - The opcode constants shared with the ALU.
- One sub-module, detector_borda: synchronizer, optional debounce and rising-edge pulse. It is instantiated twice, once per key.

Test Plan:
- Reset, then confirm with sw_data=0x2A, then confirm with sw_data=0x15 -> state 01 then 10, with A_registered=0x2A and B_registered=0x15.
- From S_B, set sw_op=3'b001 and press confirm; the ALU model returns 0x3F with alu_done 3 cycles after start -> alu_start high exactly 1 cycle, busy high for 3 cycles, result=0x3F, state=11.
- In S_RES press confirm -> state=00 and A, B, OP and result all 0x00.
- Cancel while in S_EXEC, with alu_done arriving 2 cycles later carrying 0xFF -> state=00, result stays 0x00, busy=0.
- Confirm held low for 100 cycles in S_IDLE -> exactly one capture, state=01 only; confirm and cancel pressed in the same cycle in S_A -> state=00.
- With SEQ_ULA_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a confirm glitch of 5 cycles -> no transition; stable low for 8 cycles -> one transition.
